// File: rtl/draw_rect_seq.sv
// -----------------------------------------------------------------------------
// draw_rect_seq
//
// Motion sequencer for the draggable rectangle. In FOLLOW the rectangle tracks
// the mouse (clamped to the visible area). A left click drops it: in FALL it
// moves under fixed-point gravity, one physics step per frame_tick, bouncing
// off the floor with damping until the rebound is too weak, then it sits in
// REST. A click in FALL or REST hands the rectangle back to the mouse.
//
// Optional feature (macro DRAW_RECT_SEQ_AUTO_REARM_EN): after REARM_FRAMES
// frame ticks spent in REST the sequencer returns to FOLLOW on its own.
//
// Ports:
//   clk               system clock
//   rst               asynchronous reset, active-high
//   frame_tick        one-cycle pulse per frame, advances the physics
//   mouse_left        left button level, synchronous to clk
//   mouse_x_position  mouse x (12 bit)
//   mouse_y_position  mouse y (12 bit)
//   xpos              rectangle left edge (registered)
//   ypos              rectangle top edge (registered)
//   state             0=FOLLOW, 1=FALL, 2=REST (registered)
//   at_rest           high while state==REST (registered)
// -----------------------------------------------------------------------------
module draw_rect_seq #(
    parameter int VISIBLE_WIDTH  = 800,
    parameter int VISIBLE_HEIGHT = 600,
    parameter int RECT_WIDTH     = 48,
    parameter int RECT_HEIGHT    = 64,
    parameter int GRAVITY        = 8,
    parameter int DAMP_SHIFT     = 1,
    parameter int MIN_BOUNCE_VEL = 16,
    parameter int REARM_FRAMES   = 120
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        mouse_left,
    input  logic [11:0] mouse_x_position,
    input  logic [11:0] mouse_y_position,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic [1:0]  state,
    output logic        at_rest
);

    localparam int FLOOR = VISIBLE_HEIGHT - RECT_HEIGHT;
    localparam int XMAX  = VISIBLE_WIDTH - RECT_WIDTH;

    localparam logic [11:0]        FLOOR_U  = 12'(FLOOR);
    localparam logic [11:0]        XMAX_U   = 12'(XMAX);
    localparam logic signed [13:0] FLOOR_S  = 14'(FLOOR);
    localparam logic signed [15:0] GRAV_V   = 16'(GRAVITY);
    localparam logic signed [15:0] MIN_BV_V = 16'(MIN_BOUNCE_VEL);

    // The rest counter is 8 bits wide, so the re-arm period must fit in it.
    if (REARM_FRAMES < 1 || REARM_FRAMES > 256) begin : g_bad_rearm
        $error("REARM_FRAMES must be in 1..256");
    end
    if (DAMP_SHIFT < 0 || DAMP_SHIFT > 15) begin : g_bad_damp
        $error("DAMP_SHIFT must be in 0..15");
    end

    typedef enum logic [1:0] {
        FOLLOW = 2'd0,
        FALL   = 2'd1,
        REST   = 2'd2
    } state_t;

    state_t             st_q, st_nxt;
    logic [11:0]        xpos_q, xpos_nxt;
    logic [11:0]        ypos_q, ypos_nxt;
    logic signed [15:0] vel_q, vel_nxt;
    logic               btn_d;
    logic               at_rest_q;
    logic               click;

    logic signed [15:0] vel_g;
    logic signed [13:0] disp;
    logic signed [13:0] y_cand;
    logic signed [15:0] bv;

    // Velocity add with saturation to the signed 16-bit range.
    function automatic logic signed [15:0] sat_add16(input logic signed [15:0] a,
                                                     input logic signed [15:0] b);
        logic signed [16:0] s;
        s = {a[15], a} + {b[15], b};
        if (s > 17'sd32767)
            return 16'sh7FFF;
        else if (s < -17'sd32768)
            return 16'sh8000;
        else
            return s[15:0];
    endfunction

    function automatic logic [11:0] clamp_max(input logic [11:0] v,
                                              input logic [11:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    assign click = mouse_left & ~btn_d;

    // Candidate physics step, only consumed in FALL on a tick.
    assign vel_g  = sat_add16(vel_q, GRAV_V);
    assign disp   = 14'(vel_g >>> 4);
    assign y_cand = $signed({2'b00, ypos_q}) + disp;
    assign bv     = vel_g >>> DAMP_SHIFT;

`ifdef DRAW_RECT_SEQ_AUTO_REARM_EN
    localparam logic [7:0] REARM_LAST = 8'(REARM_FRAMES - 1);
    logic [7:0] rest_cnt_q, rest_cnt_nxt;
`endif

    always_comb begin
        st_nxt   = st_q;
        xpos_nxt = xpos_q;
        ypos_nxt = ypos_q;
        vel_nxt  = vel_q;
`ifdef DRAW_RECT_SEQ_AUTO_REARM_EN
        rest_cnt_nxt = rest_cnt_q;
`endif
        unique case (st_q)
            FOLLOW: begin
                if (click) begin
                    // Rectangle is released where it currently is.
                    st_nxt  = FALL;
                    vel_nxt = '0;
                end else begin
                    xpos_nxt = clamp_max(mouse_x_position, XMAX_U);
                    ypos_nxt = clamp_max(mouse_y_position, FLOOR_U);
                end
            end
            FALL: begin
                // A click catches the block; a same-cycle tick is dropped.
                if (click) begin
                    st_nxt  = FOLLOW;
                    vel_nxt = '0;
                end else if (frame_tick) begin
                    if (y_cand >= FLOOR_S && vel_g > 16'sd0) begin
                        ypos_nxt = FLOOR_U;
                        if (bv < MIN_BV_V) begin
                            vel_nxt = '0;
                            st_nxt  = REST;
`ifdef DRAW_RECT_SEQ_AUTO_REARM_EN
                            rest_cnt_nxt = '0;
`endif
                        end else begin
                            vel_nxt = -bv;
                        end
                    end else if (y_cand < 14'sd0) begin
                        ypos_nxt = '0;
                        vel_nxt  = '0;
                    end else begin
                        ypos_nxt = y_cand[11:0];
                        vel_nxt  = vel_g;
                    end
                end
            end
            REST: begin
                ypos_nxt = FLOOR_U;
                if (click) begin
                    st_nxt = FOLLOW;
                end
`ifdef DRAW_RECT_SEQ_AUTO_REARM_EN
                else if (frame_tick) begin
                    if (rest_cnt_q == REARM_LAST)
                        st_nxt = FOLLOW;
                    rest_cnt_nxt = rest_cnt_q + 8'd1;
                end
`endif
            end
            default: begin
                st_nxt  = FOLLOW;
                vel_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q      <= FOLLOW;
            xpos_q    <= '0;
            ypos_q    <= '0;
            vel_q     <= '0;
            btn_d     <= 1'b1;
            at_rest_q <= 1'b0;
        end else begin
            st_q      <= st_nxt;
            xpos_q    <= xpos_nxt;
            ypos_q    <= ypos_nxt;
            vel_q     <= vel_nxt;
            btn_d     <= mouse_left;
            at_rest_q <= (st_nxt == REST);
        end
    end

`ifdef DRAW_RECT_SEQ_AUTO_REARM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rest_cnt_q <= '0;
        else
            rest_cnt_q <= rest_cnt_nxt;
    end
`endif

    assign xpos    = xpos_q;
    assign ypos    = ypos_q;
    assign state   = st_q;
    assign at_rest = at_rest_q;

endmodule

// File: tb/tb_draw_rect_seq.sv
// -----------------------------------------------------------------------------
// tb_draw_rect_seq
//
// Directed bench for draw_rect_seq. Each step pushes the expected registered
// outputs into a queue when its inputs are driven; after the clock edge the
// front entry is popped and compared against the DUT outputs on the falling
// edge. Optional re-arm behaviour is selected with DRAW_RECT_SEQ_AUTO_REARM_EN.
// -----------------------------------------------------------------------------
module tb_draw_rect_seq;

    logic        clk;
    logic        rst;
    logic        frame_tick;
    logic        mouse_left;
    logic [11:0] mouse_x_position;
    logic [11:0] mouse_y_position;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic [1:0]  state;
    logic        at_rest;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [11:0] x;
        logic [11:0] y;
        logic [1:0]  st;
        logic        ar;
    } exp_t;

    exp_t sb[$];

    draw_rect_seq dut (
        .clk              (clk),
        .rst              (rst),
        .frame_tick       (frame_tick),
        .mouse_left       (mouse_left),
        .mouse_x_position (mouse_x_position),
        .mouse_y_position (mouse_y_position),
        .xpos             (xpos),
        .ypos             (ypos),
        .state            (state),
        .at_rest          (at_rest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string tag, input int x, input int y,
                        input int st, input int ar);
        exp_t e;
        e.tag = tag;
        e.x   = 12'(x);
        e.y   = 12'(y);
        e.st  = 2'(st);
        e.ar  = 1'(ar);
        sb.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty observed=0 entries expected>=1");
            return;
        end
        e = sb.pop_front();
        checks++;
        assert (xpos === e.x) else begin
            failures++;
            $error("FAIL %s.xpos observed=%0d expected=%0d", e.tag, xpos, e.x);
        end
        checks++;
        assert (ypos === e.y) else begin
            failures++;
            $error("FAIL %s.ypos observed=%0d expected=%0d", e.tag, ypos, e.y);
        end
        checks++;
        assert (state === e.st) else begin
            failures++;
            $error("FAIL %s.state observed=%0d expected=%0d", e.tag, state, e.st);
        end
        checks++;
        assert (at_rest === e.ar) else begin
            failures++;
            $error("FAIL %s.at_rest observed=%0d expected=%0d", e.tag, at_rest, e.ar);
        end
    endtask

    // Advance one clock and compare on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        check_pop();
    endtask

    task automatic set_mouse(input int x, input int y);
        mouse_x_position = 12'(x);
        mouse_y_position = 12'(y);
    endtask

    // One-cycle frame tick followed by one idle cycle, checking both.
    task automatic tick_and_hold(input string tag, input int x, input int y,
                                 input int st, input int ar);
        frame_tick = 1'b1;
        push(tag, x, y, st, ar);
        step();
        frame_tick = 1'b0;
        push({tag, "_hold"}, x, y, st, ar);
        step();
    endtask

    int exp_y3 [11] = '{530, 531, 532, 534, 536, 535, 534, 534, 534, 535, 536};

    initial begin
        rst        = 1'b1;
        frame_tick = 1'b0;
        mouse_left = 1'b1;
        set_mouse(0, 0);

        // 1. Reset with the button held through it.
        repeat (2) @(negedge clk);
        push("reset", 0, 0, 0, 0);
        check_pop();
        rst = 1'b0;
        set_mouse(100, 200);
        push("follow_held", 100, 200, 0, 0);
        step();
        push("follow_held2", 100, 200, 0, 0);
        step();
        mouse_left = 1'b0;
        push("release", 100, 200, 0, 0);
        step();

        // 2. Clamping in FOLLOW.
        set_mouse(900, 700);
        push("clamp", 752, 536, 0, 0);
        step();

        // 3. Drop from y=530 with bounce and settle.
        set_mouse(300, 530);
        push("pre_drop", 300, 530, 0, 0);
        step();
        set_mouse(50, 50);
        mouse_left = 1'b1;
        push("drop_click", 300, 530, 1, 0);
        step();
        mouse_left = 1'b0;
        push("fall_frozen", 300, 530, 1, 0);
        step();
        for (int i = 0; i < 11; i++) begin
            tick_and_hold($sformatf("fall_t%0d", i + 1), 300, exp_y3[i],
                          (i == 10) ? 2 : 1, (i == 10) ? 1 : 0);
        end

        // 5. Ticks while resting.
`ifdef DRAW_RECT_SEQ_AUTO_REARM_EN
        for (int i = 1; i <= 120; i++) begin
            frame_tick = 1'b1;
            push($sformatf("rest_t%0d", i), 300, 536, (i == 120) ? 0 : 2,
                 (i == 120) ? 0 : 1);
            step();
            frame_tick = 1'b0;
        end
`else
        for (int i = 1; i <= 200; i++) begin
            frame_tick = 1'b1;
            push($sformatf("rest_t%0d", i), 300, 536, 2, 1);
            step();
            frame_tick = 1'b0;
        end
        mouse_left = 1'b1;
        push("rest_click", 300, 536, 0, 0);
        step();
`endif
        mouse_left = 1'b0;
        push("refollow", 50, 50, 0, 0);
        step();

        // 4. Click and tick in the same cycle mid-FALL.
        set_mouse(400, 100);
        push("pre_drop4", 400, 100, 0, 0);
        step();
        mouse_left = 1'b1;
        push("drop4_click", 400, 100, 1, 0);
        step();
        mouse_left = 1'b0;
        push("drop4_rel", 400, 100, 1, 0);
        step();
        tick_and_hold("fall4_t1", 400, 100, 1, 0);
        tick_and_hold("fall4_t2", 400, 101, 1, 0);
        tick_and_hold("fall4_t3", 400, 102, 1, 0);
        set_mouse(10, 20);
        mouse_left = 1'b1;
        frame_tick = 1'b1;
        push("catch_tick", 400, 102, 0, 0);
        step();
        mouse_left = 1'b0;
        frame_tick = 1'b0;
        push("catch_track", 10, 20, 0, 0);
        step();

        // 6. Asynchronous reset mid-FALL.
        set_mouse(200, 290);
        push("pre_drop6", 200, 290, 0, 0);
        step();
        mouse_left = 1'b1;
        push("drop6_click", 200, 290, 1, 0);
        step();
        mouse_left = 1'b0;
        tick_and_hold("fall6_t1", 200, 290, 1, 0);
        tick_and_hold("fall6_t2", 200, 291, 1, 0);
        #2;
        rst = 1'b1;
        #1;
        push("async_rst", 0, 0, 0, 0);
        check_pop();
        @(negedge clk);
        rst = 1'b0;
        push("post_rst", 200, 290, 0, 0);
        step();

        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_drain observed=%0d entries expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
